binary_add_arb: RTL and testbench
=================================

BINARY_ADD_ARB -- requirements
Module: binary_add_arb

Interface
REQ-001 The block SHALL have a single clock and an asynchronous active-low reset:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
REQ-002 The block SHALL have these ports:
- req  input  4  request per requester 0..3.
- op_a  input  40  operand A; requester i uses bits [10i+9:10i].
- op_b  input  40  operand B; same slicing as op_a.
- gnt  output  4  one-hot grant; high for exactly one cycle per accepted request.
- add_a  output  10  registered operand A to the shared 10-bit adder.
- add_b  output  10  registered operand B to the shared 10-bit adder.
- add_en  output  1  adder enable; the adder registers S = A+B on a rising edge while add_en=1.
- add_s  input  10  adder registered sum S.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  10  sum, mod 1024.
- res_id  output  2  index of the requester that owns res_data.
- res_ovf  output  1  carry-out of the 10-bit sum (see REQ-019).

Function
REQ-003 The FSM SHALL have four states: IDLE, EXEC, CAPT, RESP.
REQ-004 In IDLE with req != 0, at the rising edge the block SHALL:
- select the winner;
- latch that requester's operand slices into add_a/add_b;
- set gnt to the one-hot winner;
- move to EXEC.
REQ-005 In IDLE with req == 0, the block SHALL stay in IDLE with gnt=0 and add_en=0.
REQ-006 Arbitration SHALL be round-robin: the search starts at (ptr+1) mod 4, and ptr is updated to the winner index at grant.
REQ-007 In EXEC, add_en SHALL be 1 and gnt SHALL hold the winner; at the edge leaving EXEC, gnt SHALL clear and the state SHALL become CAPT.
REQ-008 In CAPT, add_en SHALL be 0; at the exiting edge the block SHALL register res_data<=add_s and res_id<=winner, set res_valid<=1, and move to RESP.
REQ-009 Latency: res_valid SHALL rise exactly 2 clock edges after the edge that raises gnt.
REQ-010 In RESP, res_valid, res_data, res_id and res_ovf SHALL hold stable until a rising edge with res_ready=1; at that edge res_valid SHALL clear and the state SHALL become IDLE.
REQ-011 Back-to-back operations: the minimum spacing between grants SHALL be 4 cycles (res_ready=1 constantly); req SHALL NOT be sampled outside IDLE.
REQ-012 A requester SHALL keep req and its operands stable until it sees its gnt; the block SHALL ignore req during EXEC, CAPT and RESP.
REQ-013 A requester that drops req before grant SHALL NOT be granted; simultaneous requests SHALL resolve by REQ-006 only.
REQ-014 Wrap-around: the sum SHALL be mod 1024 (e.g. 1023+1 -> 0); add_a/add_b SHALL hold their last values outside EXEC.

Reset
REQ-015 While rst_n=0, the block SHALL hold:
- state=IDLE;
- ptr=3 (requester 0 highest priority first);
- gnt=0, add_a=0, add_b=0, add_en=0;
- res_valid=0, res_data=0, res_id=0, res_ovf=0.
REQ-016 Reset asserted mid-operation (EXEC, CAPT or RESP) SHALL discard the in-flight result; no res_valid SHALL appear after release until a new grant.
REQ-017 After rst_n deasserts, the first grant SHALL occur at the first rising edge with req != 0.

Configuration
REQ-018 Macro ADD_ARB_OVF_EN SHALL select whether overflow detection is compiled in.
REQ-019 With ADD_ARB_OVF_EN defined:
- at grant, the block SHALL latch bit 10 of the 11-bit sum of the winner's operands;
- it SHALL present that bit on res_ovf together with res_data.
REQ-020 Without ADD_ARB_OVF_EN, res_ovf SHALL be constant 0 and no carry logic SHALL be synthesized; all other behaviour SHALL be identical.

Verification
REQ-021 Single request: req=0001, A0=5, B0=7:
- gnt=0001 for 1 cycle;
- add_en=1 in the same cycle;
- 2 edges later res_valid=1, res_data=12, res_id=0.
REQ-022 All requesting: req=1111 held, res_ready=1:
- grants SHALL follow 0,1,2,3,0, each 4 cycles apart;
- each res_id SHALL match its grant order.
REQ-023 Wrap: A2=1023, B2=1 on requester 2:
- res_data=0, res_id=2;
- res_ovf=1 with ADD_ARB_OVF_EN, 0 without.
REQ-024 Backpressure: res_ready=0 for 5 cycles after res_valid:
- res_valid, res_data and res_id SHALL hold;
- no new gnt SHALL occur despite req=1111;
- release occurs on the edge where res_ready=1.
REQ-025 Reset in CAPT:
- assert rst_n=0 for 1 cycle;
- all outputs SHALL be 0 and no res_valid SHALL appear;
- the next req=0100 SHALL be granted first (ptr=3).
REQ-026 Exhaustive sweep: a single requester SHALL cover all A,B in 0..1023 with res_ready=1, and every res_data SHALL equal (A+B) mod 1024.

Source files
------------

// File: rtl/binary_add_arb_if.sv
// ----------------------------------------------------------------------------
// binary_add_arb_if
// Bus bundle between four requesters, the arbiter, the external shared
// 10-bit adder and the result consumer.
//   req/op_a/op_b   : requester side (4 requesters, 10-bit slices per operand)
//   gnt             : one-hot grant back to the requesters
//   add_a/add_b/en  : operands/enable driven to the shared adder
//   add_s           : registered sum returned by the adder
//   res_*           : valid/ready result channel to the consumer
// modport slave  : arbiter view (binary_add_arb)
// modport master : environment view (requesters, adder, consumer)
// ----------------------------------------------------------------------------
interface binary_add_arb_if;
    logic [3:0]  req;
    logic [39:0] op_a;
    logic [39:0] op_b;
    logic [3:0]  gnt;
    logic [9:0]  add_a;
    logic [9:0]  add_b;
    logic        add_en;
    logic [9:0]  add_s;
    logic        res_valid;
    logic        res_ready;
    logic [9:0]  res_data;
    logic [1:0]  res_id;
    logic        res_ovf;

    modport slave (
        input  req, op_a, op_b, add_s, res_ready,
        output gnt, add_a, add_b, add_en, res_valid, res_data, res_id, res_ovf
    );

    modport master (
        output req, op_a, op_b, add_s, res_ready,
        input  gnt, add_a, add_b, add_en, res_valid, res_data, res_id, res_ovf
    );
endinterface

// File: rtl/binary_add_arb.sv
// ----------------------------------------------------------------------------
// binary_add_arb
// Round-robin arbiter that time-shares one external registered 10-bit adder
// among four requesters. One operation walks IDLE -> EXEC -> CAPT -> RESP:
//   IDLE : pick winner (search from ptr+1), latch its operands, raise gnt
//   EXEC : add_en=1 so the adder registers A+B on the exiting edge
//   CAPT : adder sum is now on add_s; capture it into the result regs
//   RESP : hold the result until res_ready
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : binary_add_arb_if.slave (requests, adder link, result channel)
// Build option:
//   ADD_ARB_OVF_EN : when defined, the carry-out of the winner's 11-bit sum
//                    is latched at grant and reported on res_ovf; otherwise
//                    res_ovf is tied to 0 and no carry logic exists.
// ----------------------------------------------------------------------------
module binary_add_arb (
    input  logic                  clk,
    input  logic                  rst_n,
    binary_add_arb_if.slave       bus
);
    localparam int NREQ = 4;
    localparam int W    = 10;

    typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

    state_t         state_q, state_d;
    logic [1:0]     ptr_q, ptr_d;
    logic [1:0]     win_q, win_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [W-1:0]   add_a_q, add_a_d;
    logic [W-1:0]   add_b_q, add_b_d;
    logic           add_en_q, add_en_d;
    logic           res_valid_q, res_valid_d;
    logic [W-1:0]   res_data_q, res_data_d;
    logic [1:0]     res_id_q, res_id_d;

    // Round-robin search: candidates ptr+1, ptr+2, ptr+3, ptr (2-bit wrap).
    logic [1:0]     rr_idx;
    logic [1:0]     rr_cand;
    logic           rr_hit;

    always_comb begin
        rr_idx  = ptr_q;
        rr_cand = ptr_q;
        rr_hit  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_cand = ptr_q + 2'(k);
            if (!rr_hit && bus.req[rr_cand]) begin
                rr_hit = 1'b1;
                rr_idx = rr_cand;
            end
        end
    end

    logic [W-1:0] sel_a;
    logic [W-1:0] sel_b;
    assign sel_a = bus.op_a[int'(rr_idx)*W +: W];
    assign sel_b = bus.op_b[int'(rr_idx)*W +: W];

`ifdef ADD_ARB_OVF_EN
    // Carry is computed on the operands directly since the external adder
    // only returns 10 bits.
    logic [W:0] carry_sum;
    logic       ovf_q, ovf_d;
    logic       res_ovf_q, res_ovf_d;
    assign carry_sum = {1'b0, sel_a} + {1'b0, sel_b};
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        gnt_d       = gnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_en_d    = add_en_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
`ifdef ADD_ARB_OVF_EN
        ovf_d       = ovf_q;
        res_ovf_d   = res_ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (rr_hit) begin
                    state_d  = EXEC;
                    ptr_d    = rr_idx;
                    win_d    = rr_idx;
                    gnt_d    = NREQ'(1) << rr_idx;
                    add_a_d  = sel_a;
                    add_b_d  = sel_b;
                    add_en_d = 1'b1;
`ifdef ADD_ARB_OVF_EN
                    ovf_d    = carry_sum[W];
`endif
                end
            end
            EXEC: begin
                // Adder registers A+B on this exiting edge.
                state_d  = CAPT;
                gnt_d    = '0;
                add_en_d = 1'b0;
            end
            CAPT: begin
                state_d     = RESP;
                res_data_d  = bus.add_s;
                res_id_d    = win_q;
                res_valid_d = 1'b1;
`ifdef ADD_ARB_OVF_EN
                res_ovf_d   = ovf_q;
`endif
            end
            RESP: begin
                if (bus.res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd3;
            win_q       <= '0;
            gnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= '0;
`ifdef ADD_ARB_OVF_EN
            ovf_q       <= 1'b0;
            res_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            gnt_q       <= gnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_en_q    <= add_en_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
`ifdef ADD_ARB_OVF_EN
            ovf_q       <= ovf_d;
            res_ovf_q   <= res_ovf_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_en    = add_en_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;
`ifdef ADD_ARB_OVF_EN
    assign bus.res_ovf   = res_ovf_q;
`else
    assign bus.res_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_binary_add_arb.sv
// ----------------------------------------------------------------------------
// tb_binary_add_arb
// Directed bench for binary_add_arb. An operation-level model (age counter
// since grant, pending-result flag, round-robin pointer) predicts all outputs
// and is compared against the DUT every falling edge; directed sequences add
// hand-computed literal checks. The shared adder is modelled here.
// ----------------------------------------------------------------------------
module tb_binary_add_arb;
`ifdef ADD_ARB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    binary_add_arb_if bus ();

    binary_add_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // External registered adder.
    initial bus.add_s = '0;
    always @(posedge clk) if (bus.add_en) bus.add_s <= bus.add_a + bus.add_b;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    int m_ptr = 3, m_age = 0, m_id = 0;
    int m_a = 0, m_b = 0;
    bit m_valid = 0;
    int m_data = 0, m_rid = 0, m_ovf = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr <= 3; m_age <= 0; m_id <= 0; m_a <= 0; m_b <= 0;
            m_valid <= 0; m_data <= 0; m_rid <= 0; m_ovf <= 0;
        end else if (m_age == 1) begin
            m_age <= 2;
        end else if (m_age == 2) begin
            m_age   <= 0;
            m_valid <= 1;
            m_data  <= (m_a + m_b) % 1024;
            m_ovf   <= ((m_a + m_b) >= 1024) ? 1 : 0;
            m_rid   <= m_id;
        end else if (m_valid) begin
            if (bus.res_ready) m_valid <= 0;
        end else if (bus.req != 0) begin
            m_id  <= rr_pick(bus.req, m_ptr);
            m_ptr <= rr_pick(bus.req, m_ptr);
            m_a   <= int'(bus.op_a[rr_pick(bus.req, m_ptr)*10 +: 10]);
            m_b   <= int'(bus.op_b[rr_pick(bus.req, m_ptr)*10 +: 10]);
            m_age <= 1;
        end
    end

    always @(negedge clk) begin
        chk("gnt",       bus.gnt,       (m_age == 1) ? (32'd1 << m_id) : 32'd0);
        chk("add_en",    bus.add_en,    (m_age == 1) ? 1 : 0);
        chk("add_a",     bus.add_a,     m_a);
        chk("add_b",     bus.add_b,     m_b);
        chk("res_valid", bus.res_valid, m_valid);
        chk("res_data",  bus.res_data,  m_data);
        chk("res_id",    bus.res_id,    m_rid);
        chk("res_ovf",   bus.res_ovf,   OVF_ON ? m_ovf : 0);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_ops(input int i, input int a, input int b);
        bus.op_a[i*10 +: 10] = 10'(a);
        bus.op_b[i*10 +: 10] = 10'(b);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".gnt"},   bus.gnt, 0);
        chk({nm, ".add_a"}, bus.add_a, 0);
        chk({nm, ".add_b"}, bus.add_b, 0);
        chk({nm, ".en"},    bus.add_en, 0);
        chk({nm, ".valid"}, bus.res_valid, 0);
        chk({nm, ".data"},  bus.res_data, 0);
        chk({nm, ".id"},    bus.res_id, 0);
        chk({nm, ".ovf"},   bus.res_ovf, 0);
    endtask

    task automatic sweep_op(input int a, input int b);
        set_ops(1, a, b);
        bus.req = 4'b0010;
        tick();
        bus.req = 4'b0000;
        tick(2);
        chk("sweep.data", bus.res_data, (a + b) % 1024);
        tick();
    endtask

    initial begin
        rst_n = 1'b1;
        bus.req = '0; bus.op_a = '0; bus.op_b = '0; bus.res_ready = 1'b1;
        #1 rst_n = 1'b0;
        tick(2);
        chk_zero("reset");
        rst_n = 1'b1;
        tick();

        // Single request: 5 + 7 on requester 0.
        set_ops(0, 5, 7);
        bus.req = 4'b0001;
        tick();
        chk("single.gnt", bus.gnt, 4'b0001);
        chk("single.en", bus.add_en, 1);
        chk("single.add_a", bus.add_a, 5);
        bus.req = 4'b0000;
        tick();
        chk("single.gnt_clr", bus.gnt, 0);
        chk("single.valid_early", bus.res_valid, 0);
        tick();
        chk("single.valid", bus.res_valid, 1);
        chk("single.data", bus.res_data, 12);
        chk("single.id", bus.res_id, 0);
        tick();
        chk("single.release", bus.res_valid, 0);

        // Reset so the pointer restarts at 3.
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();

        // All requesting: order 0,1,2,3,0 every 4 cycles.
        for (int i = 0; i < 4; i++) set_ops(i, 100*i + 3, i + 1);
        bus.req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("rr.gnt", bus.gnt, 32'd1 << (k % 4));
            tick(2);
            chk("rr.valid", bus.res_valid, 1);
            chk("rr.id", bus.res_id, k % 4);
            chk("rr.data", bus.res_data, 101*(k % 4) + 4);
            tick(2);
        end
        bus.req = 4'b0000;
        tick(4);

        // Wrap on requester 2 (ptr=1 now), then a short-lived req on 3.
        set_ops(2, 1023, 1);
        bus.req = 4'b0100;
        tick();
        chk("wrap.gnt", bus.gnt, 4'b0100);
        bus.req = 4'b1000;
        tick(2);
        chk("wrap.data", bus.res_data, 0);
        chk("wrap.id", bus.res_id, 2);
        chk("wrap.ovf", bus.res_ovf, OVF_ON ? 1 : 0);
        bus.req = 4'b0000;
        tick(2);
        chk("drop.nogrant", bus.gnt, 0);

        // Backpressure: ptr=2 so requester 3 (303+4) wins first.
        bus.req = 4'b1111;
        bus.res_ready = 1'b0;
        tick();
        chk("bp.gnt", bus.gnt, 4'b1000);
        tick(2);
        for (int j = 0; j < 5; j++) begin
            chk("bp.valid", bus.res_valid, 1);
            chk("bp.data", bus.res_data, 307);
            chk("bp.id", bus.res_id, 3);
            chk("bp.gnt_hold", bus.gnt, 0);
            if (j == 4) bus.res_ready = 1'b1;
            tick();
        end
        chk("bp.release", bus.res_valid, 0);
        chk("bp.gnt_idle", bus.gnt, 0);
        tick();
        chk("bp.next_gnt", bus.gnt, 4'b0001);
        bus.req = 4'b0000;
        tick(4);

        // Reset while in CAPT.
        bus.req = 4'b0010;
        tick();
        chk("rcapt.gnt", bus.gnt, 4'b0010);
        bus.req = 4'b0000;
        tick();
        rst_n = 1'b0;
        #1 chk_zero("rcapt");
        tick();
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("rcapt.no_valid", bus.res_valid, 0);
        end
        bus.req = 4'b0100;
        tick();
        chk("rcapt.first_gnt", bus.gnt, 4'b0100);
        bus.req = 4'b0000;
        tick(4);

        // Sweep of A and B across 0..1023 on requester 1.
        for (int i = 0; i < 1024; i++) begin
            sweep_op(i, (i*397 + 1) % 1024);
            sweep_op((i*211 + 7) % 1024, i);
        end
        sweep_op(1023, 1023);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
